// File: rtl/posit_encode_round_pipe_pkg.sv
// Shared definitions for the posit encode/round pipeline: derived field widths,
// special-value constants and the stage-1 flag payload.
package PositEncodeDef;

    // Fraction field width of an unpacked posit (hidden bit excluded).
    function automatic int getFractionBits(input int width, input int es);
        return width - 3 - es;
    endfunction

    // Signed exponent width able to hold +/-(width-1)*2^es.
    function automatic int getExponentBits(input int width, input int es);
        return $clog2(((width - 1) << es) + 1) + 1;
    endfunction

    // Largest positive posit: 0 followed by all ones.
    function automatic logic [63:0] maxposBits(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Smallest positive posit: 0...01.
    function automatic logic [63:0] minposBits(input int width);
        return (width > 0) ? 64'd1 : 64'd0;
    endfunction

    // NaR / infinity: 1 followed by all zeros.
    function automatic logic [63:0] infBits(input int width);
        return 64'd1 << (width - 1);
    endfunction

    // Width-independent part of the stage-1 payload; the kept body bits
    // travel next to it in their own register.
    typedef struct packed {
        logic sign;
        logic is_zero;
        logic is_inf;
        logic round_up;
        logic sat_max;
        logic sat_min;
        logic inexact;
    } s1_flags_t;

endpackage

// File: rtl/posit_encode_round_pipe_if.sv
// Stream interface for the posit encoder: unpacked posit in, packed posit out.
interface posit_encode_round_pipe_if
    import PositEncodeDef::*;
#(
    parameter int WIDTH = 8,
    parameter int ES = 1,
    parameter int TRAILING_BITS = 2
);
    localparam int FRAC_BITS = getFractionBits(WIDTH, ES);
    localparam int EXP_BITS = getExponentBits(WIDTH, ES);

    logic                       in_valid;
    logic                       in_ready;
    logic                       in_sign;
    logic                       in_isZero;
    logic                       in_isInf;
    logic signed [EXP_BITS-1:0] in_exponent;
    logic [FRAC_BITS-1:0]       in_fraction;
    logic [TRAILING_BITS-1:0]   in_trailing;
    logic                       in_sticky;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic                       out_inexact;

    // Producer of unpacked beats and consumer of packed results.
    modport master (
        output in_valid, in_sign, in_isZero, in_isInf, in_exponent,
               in_fraction, in_trailing, in_sticky, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );

    // The encoder itself.
    modport slave (
        input  in_valid, in_sign, in_isZero, in_isInf, in_exponent,
               in_fraction, in_trailing, in_sticky, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );

endinterface

// File: rtl/posit_encode_round_pipe_regime_pack.sv
// Combinational regime/es/fraction packer: builds the body string of a positive
// posit, truncates it to WIDTH-1 bits and derives rounding and saturation.
module posit_regime_pack
    import PositEncodeDef::*;
#(
    parameter int WIDTH = 8,
    parameter int ES = 1,
    parameter int TRAILING_BITS = 2,
    localparam int FRAC_BITS = getFractionBits(WIDTH, ES),
    localparam int EXP_BITS = getExponentBits(WIDTH, ES)
) (
    input  logic signed [EXP_BITS-1:0] exponent,
    input  logic [FRAC_BITS-1:0]       fraction,
    input  logic [TRAILING_BITS-1:0]   trailing,
    input  logic                       sticky,
    output logic [WIDTH-2:0]           kept,
    output logic                       round_up,
    output logic                       sat_max,
    output logic                       sat_min,
    output logic                       inexact
);
    localparam int T_W = ES + FRAC_BITS + TRAILING_BITS;
    // Two head bits, the tail, and WIDTH-1 zero pad so the longest in-range
    // regime shift never pushes tail bits off the bottom.
    localparam int V_W = WIDTH + T_W + 1;
    localparam logic signed [EXP_BITS-1:0] MAX_E = EXP_BITS'((WIDTH - 2) << ES);
    localparam logic signed [EXP_BITS-1:0] MIN_E = -MAX_E;

    logic [T_W-1:0]             tail;
    logic signed [EXP_BITS-1:0] k;
    logic [EXP_BITS-1:0]        shamt;
    logic signed [V_W-1:0]      v;
    logic signed [V_W-1:0]      v_sh;
    logic                       guard;
    logic                       rest;
    logic                       over;
    logic                       under;
    logic                       carry;
    logic                       zero_rnd;

    // es is the low ES bits of the combined exponent.
    if (ES > 0) begin : g_es
        assign tail = {exponent[ES-1:0], fraction, trailing};
    end else begin : g_no_es
        assign tail = {fraction, trailing};
    end

    // Regime via arithmetic shift: "10" shifted by k gives k+1 ones then a zero,
    // "01" shifted by -k-1 gives -k zeros then a one.
    always_comb begin
        k        = exponent >>> ES;
        shamt    = k[EXP_BITS-1] ? ~k : k;
        v        = k[EXP_BITS-1] ? {2'b01, tail, {(WIDTH - 1){1'b0}}}
                                 : {2'b10, tail, {(WIDTH - 1){1'b0}}};
        v_sh     = v >>> shamt;
        kept     = v_sh[V_W-1 -: WIDTH-1];
        guard    = v_sh[V_W-WIDTH];
        rest     = (|v_sh[V_W-WIDTH-1:0]) | sticky;
        round_up = guard & (rest | kept[0]);
        over     = exponent > MAX_E;
        under    = exponent < MIN_E;
        carry    = round_up & (&kept);
        zero_rnd = ~(|kept) & ~round_up;
        sat_max  = over | carry;
        sat_min  = ~over & (under | zero_rnd);
        inexact  = guard | rest | over | under | carry | zero_rnd;
    end

endmodule

// File: rtl/posit_encode_round_pipe.sv
// Two-stage posit encoder with round-to-nearest-even and valid/ready flow control.
// Stage 1 holds the truncated body and rounding/saturation decisions; stage 2
// holds the final signed packed posit.
module posit_encode_round_pipe
    import PositEncodeDef::*;
#(
    parameter int WIDTH = 8,
    parameter int ES = 1,
    parameter int TRAILING_BITS = 2
) (
    input logic                      clock,
    input logic                      reset,
    posit_encode_round_pipe_if.slave bus
);
    localparam logic [WIDTH-1:0] MAXPOS = WIDTH'(maxposBits(WIDTH));
    localparam logic [WIDTH-1:0] MINPOS = WIDTH'(minposBits(WIDTH));
    localparam logic [WIDTH-1:0] INF    = WIDTH'(infBits(WIDTH));

    logic             vld_p1;
    logic             vld_p2;
    logic             en_p1;
    logic             en_p2;
    logic [WIDTH-2:0] kept_c;
    logic             round_up_c;
    logic             sat_max_c;
    logic             sat_min_c;
    logic             inexact_c;
    s1_flags_t        flags_c;
    logic [WIDTH-2:0] body_p1;
    s1_flags_t        flags_p1;
    logic [WIDTH-1:0] data_p2;
    logic             inexact_p2;

    // Rounded, saturated magnitude of the positive encoding.
    function automatic logic [WIDTH-1:0] round_sat(input logic [WIDTH-2:0] body,
                                                   input s1_flags_t f);
        if (f.sat_max)
            return MAXPOS;
        else if (f.sat_min)
            return MINPOS;
        else
            return {1'b0, body} + WIDTH'(f.round_up);
    endfunction

    // Specials override everything; negatives are the two's complement.
    function automatic logic [WIDTH-1:0] finish_sign(input logic [WIDTH-1:0] mag,
                                                     input s1_flags_t f);
        if (f.is_zero)
            return '0;
        else if (f.is_inf)
            return INF;
        else if (f.sign)
            return -mag;
        else
            return mag;
    endfunction

    posit_regime_pack #(
        .WIDTH(WIDTH),
        .ES(ES),
        .TRAILING_BITS(TRAILING_BITS)
    ) u_pack (
        .exponent(bus.in_exponent),
        .fraction(bus.in_fraction),
        .trailing(bus.in_trailing),
        .sticky(bus.in_sticky),
        .kept(kept_c),
        .round_up(round_up_c),
        .sat_max(sat_max_c),
        .sat_min(sat_min_c),
        .inexact(inexact_c)
    );

    // A stage loads when empty or when the stage after it moves this cycle.
    assign en_p2        = !vld_p2 | bus.out_ready;
    assign en_p1        = !vld_p1 | en_p2;
    assign bus.in_ready = en_p1;

    // Gather the stage-1 flags; specials are never reported as inexact.
    always_comb begin
        flags_c          = '0;
        flags_c.sign     = bus.in_sign;
        flags_c.is_zero  = bus.in_isZero;
        flags_c.is_inf   = bus.in_isInf;
        flags_c.round_up = round_up_c;
        flags_c.sat_max  = sat_max_c;
        flags_c.sat_min  = sat_min_c;
        flags_c.inexact  = inexact_c & ~bus.in_isZero & ~bus.in_isInf;
    end

    // Valid bits for both stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (en_p1)
                vld_p1 <= bus.in_valid;
            if (en_p2)
                vld_p2 <= vld_p1;
        end
    end

    // ---- stage 1: truncated body and rounding/saturation decisions ----
    always_ff @(posedge clock) begin
        if (en_p1 & bus.in_valid) begin
            body_p1  <= kept_c;
            flags_p1 <= flags_c;
        end
    end

    // ---- stage 2: increment, saturate, negate into the output register ----
    always_ff @(posedge clock) begin
        if (reset) begin
            data_p2    <= '0;
            inexact_p2 <= 1'b0;
        end else if (en_p2 & vld_p1) begin
            data_p2    <= finish_sign(round_sat(body_p1, flags_p1), flags_p1);
            inexact_p2 <= flags_p1.inexact;
        end
    end

    assign bus.out_valid   = vld_p2;
    assign bus.out_data    = data_p2;
    assign bus.out_inexact = inexact_p2;

endmodule

// File: tb/tb_posit_encode_round_pipe.sv
// Directed bench for posit_encode_round_pipe at WIDTH=8, ES=1, TRAILING_BITS=2.
module tb_posit_encode_round_pipe;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    posit_encode_round_pipe_if #(.WIDTH(8), .ES(1), .TRAILING_BITS(2)) bus();

    posit_encode_round_pipe #(.WIDTH(8), .ES(1), .TRAILING_BITS(2)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    typedef struct {
        string            name;
        logic             sign;
        logic             zero;
        logic             inf;
        logic signed [4:0] e;
        logic [3:0]       frac;
        logic [1:0]       trail;
        logic             sticky;
        logic [7:0]       exp_data;
        logic             exp_inex;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string name, input logic sign, input logic zero,
                           input logic inf, input logic signed [4:0] e,
                           input logic [3:0] frac, input logic [1:0] trail,
                           input logic sticky, input logic [7:0] exp_data,
                           input logic exp_inex);
        vec_t v;
        v.name = name; v.sign = sign; v.zero = zero; v.inf = inf; v.e = e;
        v.frac = frac; v.trail = trail; v.sticky = sticky;
        v.exp_data = exp_data; v.exp_inex = exp_inex;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sign, input logic zero, input logic inf,
                         input logic signed [4:0] e, input logic [3:0] frac,
                         input logic [1:0] trail, input logic sticky);
        bus.in_sign     = sign;
        bus.in_isZero   = zero;
        bus.in_isInf    = inf;
        bus.in_exponent = e;
        bus.in_fraction = frac;
        bus.in_trailing = trail;
        bus.in_sticky   = sticky;
    endtask

    // One isolated beat with out_ready=1: offer, then wait (bounded) for the result.
    task automatic run_beat(input string name, input logic sign, input logic zero,
                            input logic inf, input logic signed [4:0] e,
                            input logic [3:0] frac, input logic [1:0] trail,
                            input logic sticky, input logic [7:0] exp_data,
                            input logic exp_inex);
        int n;
        @(negedge clock);
        drive(sign, zero, inf, e, frac, trail, sticky);
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 6) begin
            @(negedge clock);
            n++;
        end
        if (!bus.out_valid) begin
            total++; bad++;
            $display("FAIL %s: got no out_valid want out_valid within 6 cycles", name);
        end else begin
            check({name, "_data"}, 32'(bus.out_data), 32'(exp_data));
            check({name, "_inexact"}, 32'(bus.out_inexact), 32'(exp_inex));
        end
    endtask

    // Reference decoder for an 8-bit, es=1 posit (p not 0 and not NaR).
    task automatic decode(input logic [7:0] p, output logic s,
                          output logic signed [4:0] e, output logic [3:0] f);
        logic [7:0] m;
        logic [6:0] b;
        logic [6:0] r;
        logic       first;
        logic       run;
        int         n;
        int         k;
        int         cons;
        s = p[7];
        m = s ? (~p + 8'd1) : p;
        b = m[6:0];
        first = b[6];
        run = 1'b1;
        n = 0;
        for (int i = 6; i >= 0; i--) begin
            if (run && b[i] == first) n++;
            else run = 1'b0;
        end
        k = first ? n - 1 : -n;
        cons = n + 1;
        r = (cons >= 7) ? 7'd0 : 7'(b << cons);
        e = 5'(2 * k + int'(r[6]));
        f = r[5:2];
    endtask

    logic [7:0] bp_exp[8];
    logic signed [4:0] bp_e[8];
    logic bp_s[8];

    initial begin
        int sent;
        int rcv;
        int lows;
        logic held;
        logic [7:0] held_data;
        logic ds;
        logic signed [4:0] de;
        logic [3:0] df;

        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'sd0, 4'd0, 2'd0, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_inexact", 32'(bus.out_inexact), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Latency: accepted at one edge, stage 1 after it, output after the next.
        drive(1'b0, 1'b0, 1'b0, 5'sd2, 4'd0, 2'd0, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        @(negedge clock);
        check("lat_stage1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clock);
        check("lat_stage2_valid", 32'(bus.out_valid), 32'd1);
        check("lat_data", 32'(bus.out_data), 32'h60);

        add_vec("e0",           0, 0, 0,  5'sd0,   4'h0, 2'b00, 0, 8'h40, 0);
        add_vec("e0_neg",       1, 0, 0,  5'sd0,   4'h0, 2'b00, 0, 8'hC0, 0);
        add_vec("e2",           0, 0, 0,  5'sd2,   4'h0, 2'b00, 0, 8'h60, 0);
        add_vec("tie_even",     0, 0, 0,  5'sd0,   4'h0, 2'b10, 0, 8'h40, 1);
        add_vec("tie_sticky",   0, 0, 0,  5'sd0,   4'h0, 2'b10, 1, 8'h41, 1);
        add_vec("tie_odd",      0, 0, 0,  5'sd0,   4'h1, 2'b10, 0, 8'h42, 1);
        add_vec("tie_odd_neg",  1, 0, 0,  5'sd0,   4'h1, 2'b10, 0, 8'hBE, 1);
        add_vec("em1",          0, 0, 0, -5'sd1,   4'h0, 2'b00, 0, 8'h30, 0);
        add_vec("carry_regime", 0, 0, 0,  5'sd1,   4'hF, 2'b10, 0, 8'h60, 1);
        add_vec("e12_exact",    0, 0, 0,  5'sd12,  4'h0, 2'b00, 0, 8'h7F, 0);
        add_vec("e12_frac",     0, 0, 0,  5'sd12,  4'hA, 2'b00, 0, 8'h7F, 1);
        add_vec("e13_sat",      0, 0, 0,  5'sd13,  4'h0, 2'b00, 0, 8'h7F, 1);
        add_vec("em12_exact",   0, 0, 0, -5'sd12,  4'h0, 2'b00, 0, 8'h01, 0);
        add_vec("em12_trail",   0, 0, 0, -5'sd12,  4'h0, 2'b11, 0, 8'h01, 1);
        add_vec("em13_sat",     0, 0, 0, -5'sd13,  4'h0, 2'b00, 0, 8'h01, 1);
        add_vec("em13_neg",     1, 0, 0, -5'sd13,  4'h0, 2'b00, 0, 8'hFF, 1);
        add_vec("zero",         1, 1, 0,  5'sd5,   4'hF, 2'b11, 1, 8'h00, 0);
        add_vec("inf",          0, 0, 1,  5'sd3,   4'h7, 2'b01, 1, 8'h80, 0);
        add_vec("zero_and_inf", 0, 1, 1,  5'sd0,   4'h0, 2'b00, 0, 8'h00, 0);

        foreach (vq[i])
            run_beat(vq[i].name, vq[i].sign, vq[i].zero, vq[i].inf, vq[i].e,
                     vq[i].frac, vq[i].trail, vq[i].sticky,
                     vq[i].exp_data, vq[i].exp_inex);

        // Backpressure: 8 beats streamed, out_ready low for 5 cycles mid-stream.
        bp_s[0] = 0; bp_e[0] =  5'sd0; bp_exp[0] = 8'h40;
        bp_s[1] = 0; bp_e[1] =  5'sd1; bp_exp[1] = 8'h50;
        bp_s[2] = 0; bp_e[2] =  5'sd2; bp_exp[2] = 8'h60;
        bp_s[3] = 0; bp_e[3] = -5'sd1; bp_exp[3] = 8'h30;
        bp_s[4] = 0; bp_e[4] = -5'sd2; bp_exp[4] = 8'h20;
        bp_s[5] = 0; bp_e[5] =  5'sd3; bp_exp[5] = 8'h68;
        bp_s[6] = 0; bp_e[6] =  5'sd4; bp_exp[6] = 8'h70;
        bp_s[7] = 1; bp_e[7] =  5'sd0; bp_exp[7] = 8'hC0;
        sent = 0; rcv = 0; lows = 0; held = 1'b0; held_data = 8'h00;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            @(negedge clock);
            if (held) begin
                check("bp_held_valid", 32'(bus.out_valid), 32'd1);
                check("bp_held_data", 32'(bus.out_data), 32'(held_data));
            end
            bus.out_ready = !(c >= 4 && c < 9);
            if (sent < 8) begin
                drive(bp_s[sent], 1'b0, 1'b0, bp_e[sent], 4'h0, 2'b00, 1'b0);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", 32'(bus.in_ready), 32'(((sent - rcv) < 2) || bus.out_ready));
            if (!bus.in_ready) lows++;
            if (bus.out_valid && bus.out_ready) begin
                check("bp_order", 32'(bus.out_data), 32'(bp_exp[rcv]));
                rcv++;
            end
            held = bus.out_valid & !bus.out_ready;
            held_data = bus.out_data;
            if (bus.in_valid && bus.in_ready) sent++;
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_received", 32'(rcv), 32'd8);
        check("bp_in_ready_dropped", 32'(lows > 0), 32'd1);

        // Reset with both stages holding beats.
        bus.out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'sd2, 4'h0, 2'b00, 1'b0);
        bus.in_valid = 1'b1;
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 5'sd2, 4'h0, 2'b00, 1'b0);
        @(negedge clock);
        bus.in_valid = 1'b0;
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_data", 32'(bus.out_data), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("midrst_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Every 8-bit posit round-trips through its decoded fields.
        for (int p = 0; p < 256; p++) begin
            if (p == 0) begin
                run_beat($sformatf("exh_%02h", p), 1'b0, 1'b1, 1'b0, 5'sd0, 4'h0,
                         2'b00, 1'b0, 8'(p), 1'b0);
            end else if (p == 128) begin
                run_beat($sformatf("exh_%02h", p), 1'b0, 1'b0, 1'b1, 5'sd0, 4'h0,
                         2'b00, 1'b0, 8'(p), 1'b0);
            end else begin
                decode(8'(p), ds, de, df);
                run_beat($sformatf("exh_%02h", p), ds, 1'b0, 1'b0, de, df,
                         2'b00, 1'b0, 8'(p), 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
